// File: rtl/i2c_target_regs_if.sv
// Open-drain I2C pad bundle between a host (bench or board pads) and the target.
// The target only ever pulls SDA low through sda_oe and never touches SCL.
interface i2c_target_regs_if;
    logic scl_in;
    logic sda_in;
    logic sda_oe;

    modport master (output scl_in, output sda_in, input sda_oe);
    modport slave  (input scl_in, input sda_in, output sda_oe);
endinterface

// File: rtl/i2c_target_regs.sv
// I2C target with a 16 x 8-bit register bank: filtered line sampling, START/STOP
// detection, pointer writes, burst writes and pointer-based burst reads.
module i2c_target_regs #(
    parameter logic [6:0] DEV_ADDR    = 7'h5D,
    parameter int         FILT_CYCLES = 4,
    parameter logic [3:0] STATUS_ADDR = 4'hF
) (
    input  logic                    clk,
    input  logic                    reset,
    i2c_target_regs_if.slave        bus,
    input  logic [7:0]              status_in,
    output logic [127:0]            regs_flat,
    output logic                    wr_stb,
    output logic [3:0]              wr_addr,
    output logic [7:0]              wr_data,
    output logic                    busy
);

    // state  | meaning
    // IDLE   | bus free, waiting for START
    // ADDR   | shifting in the address byte, ACK on match
    // PTR    | receiving the register pointer byte
    // WR     | receiving data bytes into bank[pointer]
    // RD     | shifting bank[pointer] out, sampling host ACK/NACK
    // IGNORE | not addressed or host NACKed; wait for START/STOP
    typedef enum logic [2:0] {IDLE, ADDR, PTR, WR, RD, IGNORE} state_t;

    localparam int                CW        = $clog2(FILT_CYCLES + 1);
    localparam logic [CW-1:0]     FILT_LOAD = CW'(FILT_CYCLES - 1);

    logic [1:0]    scl_sync_q, sda_sync_q;
    logic [CW-1:0] scl_cnt_q, sda_cnt_q;
    logic          scl_filt_q, sda_filt_q, scl_prev_q, sda_prev_q;
    logic          scl_rise_q, scl_fall_q, start_q, stop_q, sda_smp_q;

    state_t        state_q;
    logic [3:0]    bit_cnt_q;
    logic [7:0]    shreg_q;
    logic [3:0]    ptr_q;
    logic          rw_q;
    logic          sda_oe_q;
    logic          busy_q;
    logic          wr_stb_q;
    logic [3:0]    wr_addr_q;
    logic [7:0]    wr_data_q;
    logic [7:0]    bank_q [16];

    logic [7:0]    rx_byte_d;
    logic [7:0]    rd_byte_d;

    assign rx_byte_d = {shreg_q[6:0], sda_smp_q};
    assign rd_byte_d = (ptr_q == STATUS_ADDR) ? status_in : bank_q[ptr_q];

    // Down-counter reloads whenever the synchronized line agrees with the
    // filtered value, so only an unbroken run of differing samples reaches zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_cnt_q  <= FILT_LOAD;
            sda_cnt_q  <= FILT_LOAD;
            scl_filt_q <= 1'b1;
            sda_filt_q <= 1'b1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
            scl_rise_q <= 1'b0;
            scl_fall_q <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
            sda_smp_q  <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[0], bus.scl_in};
            sda_sync_q <= {sda_sync_q[0], bus.sda_in};

            if (scl_sync_q[1] == scl_filt_q) begin
                scl_cnt_q <= FILT_LOAD;
            end else if (scl_cnt_q == '0) begin
                scl_filt_q <= scl_sync_q[1];
                scl_cnt_q  <= FILT_LOAD;
            end else begin
                scl_cnt_q <= scl_cnt_q - 1'b1;
            end

            if (sda_sync_q[1] == sda_filt_q) begin
                sda_cnt_q <= FILT_LOAD;
            end else if (sda_cnt_q == '0) begin
                sda_filt_q <= sda_sync_q[1];
                sda_cnt_q  <= FILT_LOAD;
            end else begin
                sda_cnt_q <= sda_cnt_q - 1'b1;
            end

            scl_prev_q <= scl_filt_q;
            sda_prev_q <= sda_filt_q;
            scl_rise_q <= scl_filt_q & ~scl_prev_q;
            scl_fall_q <= ~scl_filt_q & scl_prev_q;
            start_q    <= scl_filt_q & scl_prev_q & ~sda_filt_q & sda_prev_q;
            stop_q     <= scl_filt_q & scl_prev_q & sda_filt_q & ~sda_prev_q;
            sda_smp_q  <= sda_filt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            bit_cnt_q <= 4'd0;
            shreg_q   <= 8'h00;
            ptr_q     <= 4'd0;
            rw_q      <= 1'b0;
            sda_oe_q  <= 1'b0;
            busy_q    <= 1'b0;
            wr_stb_q  <= 1'b0;
            wr_addr_q <= 4'd0;
            wr_data_q <= 8'h00;
            for (int i = 0; i < 16; i++) bank_q[i] <= 8'h00;
        end else begin
            wr_stb_q <= 1'b0;
            // Bank commit trails the strobe by one cycle.
            if (wr_stb_q && (wr_addr_q != STATUS_ADDR)) bank_q[wr_addr_q] <= wr_data_q;

            if (start_q) begin
                state_q   <= ADDR;
                bit_cnt_q <= 4'd0;
                sda_oe_q  <= 1'b0;
            end else if (stop_q) begin
                state_q   <= IDLE;
                bit_cnt_q <= 4'd0;
                sda_oe_q  <= 1'b0;
                busy_q    <= 1'b0;
            end else begin
                case (state_q)
                    ADDR, PTR, WR: begin
                        if (scl_rise_q) begin
                            if (bit_cnt_q < 4'd8) begin
                                shreg_q   <= rx_byte_d;
                                bit_cnt_q <= bit_cnt_q + 4'd1;
                                if (bit_cnt_q == 4'd7) begin
                                    case (state_q)
                                        ADDR: begin
                                            if (rx_byte_d[7:1] == DEV_ADDR) begin
                                                busy_q <= 1'b1;
                                                rw_q   <= rx_byte_d[0];
                                            end else begin
                                                state_q   <= IGNORE;
                                                bit_cnt_q <= 4'd0;
                                                busy_q    <= 1'b0;
                                            end
                                        end
                                        PTR: ptr_q <= rx_byte_d[3:0];
                                        default: begin
                                            wr_stb_q  <= 1'b1;
                                            wr_addr_q <= ptr_q;
                                            wr_data_q <= rx_byte_d;
                                            ptr_q     <= ptr_q + 4'd1;
                                        end
                                    endcase
                                end
                            end else if (bit_cnt_q == 4'd8) begin
                                bit_cnt_q <= 4'd9;
                            end
                        end else if (scl_fall_q) begin
                            if (bit_cnt_q == 4'd8) begin
                                sda_oe_q <= 1'b1;
                            end else if (bit_cnt_q == 4'd9) begin
                                bit_cnt_q <= 4'd0;
                                if (state_q == ADDR && rw_q) begin
                                    state_q  <= RD;
                                    shreg_q  <= rd_byte_d;
                                    sda_oe_q <= ~rd_byte_d[7];
                                    ptr_q    <= ptr_q + 4'd1;
                                end else begin
                                    sda_oe_q <= 1'b0;
                                    state_q  <= (state_q == ADDR) ? PTR : WR;
                                end
                            end
                        end
                    end
                    RD: begin
                        if (scl_rise_q) begin
                            if (bit_cnt_q < 4'd8) begin
                                bit_cnt_q <= bit_cnt_q + 4'd1;
                            end else if (sda_smp_q) begin
                                state_q   <= IGNORE;
                                bit_cnt_q <= 4'd0;
                                busy_q    <= 1'b0;
                            end else begin
                                bit_cnt_q <= 4'd9;
                            end
                        end else if (scl_fall_q) begin
                            if (bit_cnt_q == 4'd8) begin
                                sda_oe_q <= 1'b0;
                            end else if (bit_cnt_q == 4'd9) begin
                                bit_cnt_q <= 4'd0;
                                shreg_q   <= rd_byte_d;
                                sda_oe_q  <= ~rd_byte_d[7];
                                ptr_q     <= ptr_q + 4'd1;
                            end else if (bit_cnt_q != 4'd0) begin
                                shreg_q  <= {shreg_q[6:0], 1'b0};
                                sda_oe_q <= ~shreg_q[6];
                            end
                        end
                    end
                    default: sda_oe_q <= 1'b0;
                endcase
            end
        end
    end

    for (genvar g = 0; g < 16; g++) begin : g_flat
        assign regs_flat[8*g +: 8] = bank_q[g];
    end

    assign bus.sda_oe = sda_oe_q;
    assign wr_stb     = wr_stb_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign busy       = busy_q;

endmodule
